// File: rtl/dsp_rdata_ordered_channel.sv
// dsp_rdata_ordered_channel: returns R beats from SLV_AMT slave ports to one master port,
// strictly in AR issue order, using an internal queue of target slave IDs plus per-slave FWFT FIFOs.
`default_nettype none

module dsp_rdata_ordered_channel #(
  parameter int SLV_AMT         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int RESP_W          = 2,
  parameter int DSP_RDATA_DEPTH = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
  parameter int OST_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic                                ar_push_i,
  input  logic [SLV_ID_W-1:0]                 ar_slv_id_i,
  output logic                                ar_ready_o,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]   sa_RID_i,
  input  logic [DATA_WIDTH*SLV_AMT-1:0]       sa_RDATA_i,
  input  logic [RESP_W*SLV_AMT-1:0]           sa_RRESP_i,
  input  logic [SLV_AMT-1:0]                  sa_RLAST_i,
  input  logic [SLV_AMT-1:0]                  sa_RVALID_i,
  output logic [SLV_AMT-1:0]                  sa_RREADY_o,
  input  logic                                m_RREADY_i,
  output logic [TRANS_MST_ID_W-1:0]           m_RID_o,
  output logic [DATA_WIDTH-1:0]               m_RDATA_o,
  output logic [RESP_W-1:0]                   m_RRESP_o,
  output logic                                m_RLAST_o,
  output logic                                m_RVALID_o,
  output logic [OST_W-1:0]                    outstanding_o,
  output logic                                err_illegal_id_o
);

  localparam int FIFO_AW = $clog2(DSP_RDATA_DEPTH);
  localparam int Q_AW    = $clog2(MAX_OUTSTANDING);
  localparam int BEAT_W  = TRANS_MST_ID_W + DATA_WIDTH + RESP_W + 1;
  localparam logic [SLV_ID_W:0] SLV_AMT_C = (SLV_ID_W + 1)'(SLV_AMT);

  logic [BEAT_W-1:0]   fifo_dout [SLV_AMT];
  logic [SLV_AMT-1:0]  fifo_empty;
  logic [SLV_ID_W-1:0] head;
  logic [BEAT_W-1:0]   head_beat;
  logic                m_hs;
  logic                q_push;
  logic                q_pop;
  logic                q_full;
  logic                q_empty;
  logic                id_legal;
  logic [Q_AW:0]       q_wr;
  logic [Q_AW:0]       q_rd;
  logic [SLV_ID_W-1:0] q_mem [MAX_OUTSTANDING];
  logic [OST_W-1:0]    ost;
  logic                err;

  // Per-slave first-word-fall-through FIFOs; beat packed as {rid, rdata, rresp, rlast}.
  for (genvar s = 0; s < SLV_AMT; s++) begin : g_fifo
    logic [BEAT_W-1:0]  mem [DSP_RDATA_DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               full;
    logic               wr_en;
    logic               rd_en;
    logic [BEAT_W-1:0]  beat_in;

    assign beat_in = {sa_RID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                      sa_RDATA_i[s*DATA_WIDTH +: DATA_WIDTH],
                      sa_RRESP_i[s*RESP_W +: RESP_W],
                      sa_RLAST_i[s]};
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign wr_en = sa_RVALID_i[s] & ~full;
    assign rd_en = m_hs & (head == SLV_ID_W'(s));

    assign sa_RREADY_o[s] = ~full;
    assign fifo_empty[s]  = (wr_ptr == rd_ptr);
    assign fifo_dout[s]   = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge ACLK_i) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= beat_in;
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign q_empty  = (q_wr == q_rd);
  assign q_full   = (q_wr[Q_AW] != q_rd[Q_AW]) && (q_wr[Q_AW-1:0] == q_rd[Q_AW-1:0]);
  assign id_legal = ({1'b0, ar_slv_id_i} < SLV_AMT_C);

  if (SLV_AMT == 1) begin : g_head_const
    assign head = '0;
  end else begin : g_head_queue
    assign head = q_mem[q_rd[Q_AW-1:0]];
  end

  assign m_RVALID_o = ~q_empty & ~fifo_empty[head];
  assign head_beat  = fifo_dout[head];
  assign m_hs       = m_RVALID_o & m_RREADY_i;
  assign q_pop      = m_hs & head_beat[0];
  // A push at full still lands when the head burst retires in the same cycle: the slot is freed.
  assign q_push     = ar_push_i & id_legal & (~q_full | q_pop);

  assign ar_ready_o       = ~q_full;
  assign outstanding_o    = ost;
  assign err_illegal_id_o = err;

  always_comb begin
    {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = '0;
    if (m_RVALID_o) {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = head_beat;
  end

  always_ff @(posedge ACLK_i) begin
    if (q_push) q_mem[q_wr[Q_AW-1:0]] <= ar_slv_id_i;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      q_wr <= '0;
      q_rd <= '0;
      ost  <= '0;
      err  <= 1'b0;
    end else begin
      if (q_push) q_wr <= q_wr + 1'b1;
      if (q_pop)  q_rd <= q_rd + 1'b1;
      if (q_push && !q_pop)      ost <= ost + 1'b1;
      else if (!q_push && q_pop) ost <= ost - 1'b1;
      if (ar_push_i && !id_legal) err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsp_rdata_ordered_channel.sv
// Self-checking bench: hand-derived vector table, directed corner sequences, and randomized
// traffic compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_dsp_rdata_ordered_channel;
  localparam int SLV_AMT = 3;
  localparam int DATA_WIDTH = 16;
  localparam int TRANS_MST_ID_W = 5;
  localparam int RESP_W = 2;
  localparam int DSP_RDATA_DEPTH = 16;
  localparam int MAX_OUTSTANDING = 4;
  localparam int SLV_ID_W = 2;
  localparam int OST_W = 3;

  logic ACLK_i = 1'b0;
  logic ARESETn_i;
  logic ar_push_i;
  logic [SLV_ID_W-1:0] ar_slv_id_i;
  logic ar_ready_o;
  logic [TRANS_MST_ID_W*SLV_AMT-1:0] sa_RID_i;
  logic [DATA_WIDTH*SLV_AMT-1:0] sa_RDATA_i;
  logic [RESP_W*SLV_AMT-1:0] sa_RRESP_i;
  logic [SLV_AMT-1:0] sa_RLAST_i;
  logic [SLV_AMT-1:0] sa_RVALID_i;
  logic [SLV_AMT-1:0] sa_RREADY_o;
  logic m_RREADY_i;
  logic [TRANS_MST_ID_W-1:0] m_RID_o;
  logic [DATA_WIDTH-1:0] m_RDATA_o;
  logic [RESP_W-1:0] m_RRESP_o;
  logic m_RLAST_o;
  logic m_RVALID_o;
  logic [OST_W-1:0] outstanding_o;
  logic err_illegal_id_o;

  always #5 ACLK_i = ~ACLK_i;

  dsp_rdata_ordered_channel #(
    .SLV_AMT(SLV_AMT), .DATA_WIDTH(DATA_WIDTH), .TRANS_MST_ID_W(TRANS_MST_ID_W),
    .RESP_W(RESP_W), .DSP_RDATA_DEPTH(DSP_RDATA_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
    .ar_push_i(ar_push_i), .ar_slv_id_i(ar_slv_id_i), .ar_ready_o(ar_ready_o),
    .sa_RID_i(sa_RID_i), .sa_RDATA_i(sa_RDATA_i), .sa_RRESP_i(sa_RRESP_i),
    .sa_RLAST_i(sa_RLAST_i), .sa_RVALID_i(sa_RVALID_i), .sa_RREADY_o(sa_RREADY_o),
    .m_RREADY_i(m_RREADY_i), .m_RID_o(m_RID_o), .m_RDATA_o(m_RDATA_o),
    .m_RRESP_o(m_RRESP_o), .m_RLAST_o(m_RLAST_o), .m_RVALID_o(m_RVALID_o),
    .outstanding_o(outstanding_o), .err_illegal_id_o(err_illegal_id_o)
  );

  typedef struct packed {
    logic [TRANS_MST_ID_W-1:0] rid;
    logic [DATA_WIDTH-1:0]     data;
    logic [RESP_W-1:0]         resp;
    logic                      last;
  } beat_t;

  // Slave-side drivers.
  beat_t drv [SLV_AMT];
  logic [SLV_AMT-1:0] drv_valid;

  always_comb begin
    sa_RID_i = '0;
    sa_RDATA_i = '0;
    sa_RRESP_i = '0;
    sa_RLAST_i = '0;
    for (int s = 0; s < SLV_AMT; s++) begin
      sa_RID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W] = drv[s].rid;
      sa_RDATA_i[s*DATA_WIDTH +: DATA_WIDTH] = drv[s].data;
      sa_RRESP_i[s*RESP_W +: RESP_W] = drv[s].resp;
      sa_RLAST_i[s] = drv[s].last;
    end
    sa_RVALID_i = drv_valid;
  end

  // Reference model: buffered beats per slave, AR order as a queue of slave IDs.
  beat_t sq [SLV_AMT][$];
  int oq[$];
  logic m_err;
  logic [SLV_AMT-1:0] acc_r;

  int n_chk = 0;
  int n_pass = 0;
  int n7 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SLV_AMT; s++) sq[s].delete();
    oq.delete();
    m_err = 1'b0;
    acc_r = '0;
  endtask

  task automatic model_check();
    bit ev;
    beat_t hb;
    ev = (oq.size() > 0) && (sq[oq[0]].size() > 0);
    hb = ev ? sq[oq[0]][0] : '0;
    chk("m_RVALID", m_RVALID_o, ev);
    chk("m_RID", m_RID_o, hb.rid);
    chk("m_RDATA", m_RDATA_o, hb.data);
    chk("m_RRESP", m_RRESP_o, hb.resp);
    chk("m_RLAST", m_RLAST_o, hb.last);
    for (int s = 0; s < SLV_AMT; s++)
      chk($sformatf("sa_RREADY[%0d]", s), sa_RREADY_o[s], sq[s].size() < DSP_RDATA_DEPTH);
    chk("ar_ready", ar_ready_o, oq.size() < MAX_OUTSTANDING);
    chk("outstanding", outstanding_o, oq.size());
    chk("err_illegal_id", err_illegal_id_o, m_err);
  endtask

  task automatic model_step();
    bit ev, popped, was_full;
    beat_t b;
    ev = (oq.size() > 0) && (sq[oq[0]].size() > 0);
    was_full = (oq.size() >= MAX_OUTSTANDING);
    popped = 1'b0;
    for (int s = 0; s < SLV_AMT; s++)
      acc_r[s] = drv_valid[s] && (sq[s].size() < DSP_RDATA_DEPTH);
    if (ev && m_RREADY_i) begin
      b = sq[oq[0]].pop_front();
      if (b.last) begin
        void'(oq.pop_front());
        popped = 1'b1;
      end
    end
    for (int s = 0; s < SLV_AMT; s++)
      if (acc_r[s]) sq[s].push_back(drv[s]);
    if (ar_push_i) begin
      if (int'(ar_slv_id_i) >= SLV_AMT) m_err = 1'b1;
      else if (!was_full || popped) oq.push_back(int'(ar_slv_id_i));
    end
  endtask

  task automatic cycle();
    @(negedge ACLK_i);
    model_check();
    if (m_RVALID_o && m_RREADY_i && m_RID_o == 5'd7) n7++;
    model_step();
    @(posedge ACLK_i);
    #1;
  endtask

  task automatic idle_inputs();
    ar_push_i = 1'b0;
    ar_slv_id_i = '0;
    drv_valid = '0;
    for (int s = 0; s < SLV_AMT; s++) drv[s] = '0;
    m_RREADY_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESETn_i = 1'b0;
    model_reset();
    repeat (2) @(posedge ACLK_i);
    #1;
    ARESETn_i = 1'b1;
  endtask

  typedef struct {
    int push, id, slv, rid, data, resp, last, rr;
    int ev, erid, edata, eresp, elast, eost, eerr;
  } vec_t;
  vec_t tv [11];

  initial begin
    int k;
    bit s0_done;

    // Push slave 1 then slave 0; slave 0 answers first, but B0 must come out first.
    tv[0]  = '{1, 1, -1, 0, 0,       0, 0, 1,  0, 0, 0,       0, 0, 0, 0};
    tv[1]  = '{1, 0,  0, 3, 'hA0A0,  0, 0, 1,  0, 0, 0,       0, 0, 1, 0};
    tv[2]  = '{0, 0,  0, 3, 'hA1A1,  0, 1, 1,  0, 0, 0,       0, 0, 2, 0};
    tv[3]  = '{0, 0,  1, 4, 'hB0B0,  2, 1, 1,  0, 0, 0,       0, 0, 2, 0};
    tv[4]  = '{0, 0, -1, 0, 0,       0, 0, 1,  1, 4, 'hB0B0,  2, 1, 2, 0};
    tv[5]  = '{0, 0, -1, 0, 0,       0, 0, 1,  1, 3, 'hA0A0,  0, 0, 1, 0};
    tv[6]  = '{0, 0, -1, 0, 0,       0, 0, 1,  1, 3, 'hA1A1,  0, 1, 1, 0};
    tv[7]  = '{0, 0, -1, 0, 0,       0, 0, 1,  0, 0, 0,       0, 0, 0, 0};
    // Illegal slave ID 3: nothing queued, sticky error from the next cycle.
    tv[8]  = '{1, 3, -1, 0, 0,       0, 0, 1,  0, 0, 0,       0, 0, 0, 0};
    tv[9]  = '{0, 0, -1, 0, 0,       0, 0, 1,  0, 0, 0,       0, 0, 0, 1};
    tv[10] = '{0, 0, -1, 0, 0,       0, 0, 1,  0, 0, 0,       0, 0, 0, 1};

    idle_inputs();
    ARESETn_i = 1'b0;
    #1;
    chk("reset m_RVALID", m_RVALID_o, 0);
    chk("reset sa_RREADY", sa_RREADY_o, 3'b111);
    chk("reset ar_ready", ar_ready_o, 1);
    chk("reset outstanding", outstanding_o, 0);
    chk("reset err", err_illegal_id_o, 0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      ar_push_i = tv[i].push[0];
      ar_slv_id_i = SLV_ID_W'(tv[i].id);
      m_RREADY_i = tv[i].rr[0];
      if (tv[i].slv >= 0) begin
        drv_valid[tv[i].slv] = 1'b1;
        drv[tv[i].slv] = '{rid: 5'(tv[i].rid), data: 16'(tv[i].data),
                           resp: 2'(tv[i].resp), last: tv[i].last[0]};
      end
      @(negedge ACLK_i);
      chk($sformatf("vec%0d m_RVALID", i), m_RVALID_o, tv[i].ev);
      chk($sformatf("vec%0d m_RID", i), m_RID_o, tv[i].erid);
      chk($sformatf("vec%0d m_RDATA", i), m_RDATA_o, tv[i].edata);
      chk($sformatf("vec%0d m_RRESP", i), m_RRESP_o, tv[i].eresp);
      chk($sformatf("vec%0d m_RLAST", i), m_RLAST_o, tv[i].elast);
      chk($sformatf("vec%0d outstanding", i), outstanding_o, tv[i].eost);
      chk($sformatf("vec%0d err", i), err_illegal_id_o, tv[i].eerr);
      model_check();
      model_step();
      @(posedge ACLK_i);
      #1;
    end

    // Order queue fills at 4; a fifth push is dropped; push + RLAST pop at full keeps 4.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      ar_push_i = 1'b1;
      chk($sformatf("fill ar_ready before push %0d", i), ar_ready_o, i < 4);
      cycle();
    end
    chk("full outstanding", outstanding_o, 4);
    chk("full ar_ready", ar_ready_o, 0);
    idle_inputs();
    drv_valid[0] = 1'b1;
    drv[0] = '{rid: 5'd1, data: 16'h1234, resp: 2'd0, last: 1'b1};
    cycle();
    idle_inputs();
    chk("full head valid", m_RVALID_o, 1);
    ar_push_i = 1'b1;
    ar_slv_id_i = 2'd2;
    m_RREADY_i = 1'b1;
    cycle();
    chk("push+pop at full outstanding", outstanding_o, 4);
    chk("push+pop at full ar_ready", ar_ready_o, 0);

    // Non-head slave 1 streams 17 beats into a 16-deep FIFO, then drains in order.
    do_reset();
    idle_inputs();
    ar_push_i = 1'b1; ar_slv_id_i = 2'd0; cycle();
    ar_push_i = 1'b1; ar_slv_id_i = 2'd1; cycle();
    idle_inputs();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      drv_valid[1] = (k < 17);
      drv[1] = '{rid: 5'd7, data: 16'(16'h1000 + k), resp: 2'(k), last: (k == 16)};
      cycle();
      if (acc_r[1]) k++;
    end
    chk("backpressure beats accepted", k, 16);
    chk("backpressure sa_RREADY[1]", sa_RREADY_o[1], 0);
    n7 = 0;
    s0_done = 1'b0;
    m_RREADY_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drv_valid[0] = !s0_done;
      drv[0] = '{rid: 5'd2, data: 16'h5A5A, resp: 2'd0, last: 1'b1};
      drv_valid[1] = (k < 17);
      drv[1] = '{rid: 5'd7, data: 16'(16'h1000 + k), resp: 2'(k), last: (k == 16)};
      cycle();
      if (acc_r[0]) s0_done = 1'b1;
      if (acc_r[1]) k++;
    end
    chk("backpressure all accepted", k, 17);
    chk("backpressure beats delivered", n7, 17);
    chk("backpressure outstanding", outstanding_o, 0);

    // Master stalls for 5 cycles: beat and valid hold, then one handshake retires it.
    do_reset();
    idle_inputs();
    ar_push_i = 1'b1; ar_slv_id_i = 2'd2; cycle();
    idle_inputs();
    drv_valid[2] = 1'b1;
    drv[2] = '{rid: 5'd9, data: 16'hC0DE, resp: 2'd1, last: 1'b1};
    cycle();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d m_RVALID", c), m_RVALID_o, 1);
      chk($sformatf("stall%0d m_RDATA", c), m_RDATA_o, 16'hC0DE);
      chk($sformatf("stall%0d m_RID", c), m_RID_o, 5'd9);
      cycle();
    end
    m_RREADY_i = 1'b1;
    cycle();
    chk("stall accepted m_RVALID", m_RVALID_o, 0);
    chk("stall accepted outstanding", outstanding_o, 0);

    // Asynchronous reset with three beats buffered.
    do_reset();
    idle_inputs();
    ar_push_i = 1'b1; ar_slv_id_i = 2'd0; cycle();
    idle_inputs();
    for (int b = 0; b < 3; b++) begin
      drv_valid[0] = 1'b1;
      drv[0] = '{rid: 5'd5, data: 16'(16'hD000 + b), resp: 2'd0, last: (b == 2)};
      cycle();
    end
    idle_inputs();
    chk("pre-reset m_RVALID", m_RVALID_o, 1);
    #2;
    ARESETn_i = 1'b0;
    #1;
    chk("async reset m_RVALID", m_RVALID_o, 0);
    chk("async reset outstanding", outstanding_o, 0);
    chk("async reset m_RDATA", m_RDATA_o, 0);
    chk("async reset sa_RREADY", sa_RREADY_o, 3'b111);
    chk("async reset ar_ready", ar_ready_o, 1);
    model_reset();
    @(posedge ACLK_i);
    #1;
    ARESETn_i = 1'b1;
    m_RREADY_i = 1'b1;
    repeat (4) cycle();
    chk("post-reset no stale beat", m_RVALID_o, 0);

    // Randomized traffic against the reference model.
    do_reset();
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < SLV_AMT; s++) begin
        if (!drv_valid[s] || acc_r[s]) begin
          drv_valid[s] = ($urandom_range(0, 99) < 50);
          drv[s] = '{rid: 5'($urandom), data: 16'($urandom), resp: 2'($urandom),
                     last: ($urandom_range(0, 2) == 0)};
        end
      end
      ar_push_i = ($urandom_range(0, 3) == 0);
      ar_slv_id_i = ($urandom_range(0, 49) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      m_RREADY_i = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
